// File: rtl/synckey_debounce.sv
// synckey_debounce: keypad front end. Synchronises a raw N-bit key vector,
// debounces both press and release, encodes the accepted key to a binary
// index and raises a strobe for each new press (pulse or level).
module synckey_debounce #(
    parameter int NKEYS           = 20,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_MODE      = 1,
    localparam int OUTW           = $clog2(NKEYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] in,
    output logic             strobe,
    output logic [OUTW-1:0]  out,
    output logic             multi
);

    localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    logic [NKEYS-1:0] sync_q [SYNC_STAGES];
    logic [NKEYS-1:0] sv;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [NKEYS-1:0] cap_q, cap_d;
    logic [OUTW-1:0]  out_d;
    logic             multi_d;
    logic             strobe_d;

    // Index of the highest set bit; later (higher) bits overwrite earlier ones.
    function automatic logic [OUTW-1:0] encode(input logic [NKEYS-1:0] v);
        logic [OUTW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (v[i]) idx = OUTW'(i);
        end
        return idx;
    endfunction

    // Synchroniser chain per key; the last stage is the debouncer's view of the keypad.
    // NOTE: the sync flops are reset explicitly so a key held across reset is
    // seen as a fresh press and goes through the full latency again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, so the chain really is SYNC_STAGES deep.
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sv = sync_q[SYNC_STAGES-1];

    // State, counter, captured pattern and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            out     <= '0;
            multi   <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            out     <= out_d;
            multi   <= multi_d;
            strobe  <= strobe_d;
        end
    end

    // Next-state and next-output logic of the press/release debouncer.
    always_comb begin
        // NOTE: every target gets a default first so no path through the
        // case statement leaves a signal unassigned (which would infer a latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        out_d    = out;
        multi_d  = multi;
        strobe_d = (PULSE_MODE != 0) ? 1'b0 : strobe;

        unique case (state_q)
            IDLE: begin
                if (sv != '0) begin
                    cap_d   = sv;
                    cnt_d   = CNT_ONE;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sv == '0) begin
                    state_d = IDLE;
                end else if (sv == cap_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = HELD;
                        out_d    = encode(cap_q);
                        // More than one bit set iff clearing the lowest set bit leaves something.
                        multi_d  = |(cap_q & (cap_q - NKEYS'(1)));
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cap_d = sv;
                    cnt_d = CNT_ONE;
                end
            end
            HELD: begin
                if (sv == '0) begin
                    state_d = RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE: begin
                if (sv != '0) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    strobe_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_synckey_debounce.sv
// tb_synckey_debounce: directed bench for synckey_debounce. A pulse-mode and a
// level-mode instance share clock, reset and key inputs.
module tb_synckey_debounce;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] in  = '0;

    logic        strobe, multi;
    logic [4:0]  out;
    logic        lvl_strobe, lvl_multi;
    logic [4:0]  lvl_out;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;
    int base;

    synckey_debounce dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .strobe (strobe),
        .out    (out),
        .multi  (multi)
    );

    synckey_debounce #(.PULSE_MODE(0)) dut_lvl (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .strobe (lvl_strobe),
        .out    (lvl_out),
        .multi  (lvl_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, sample 1 time unit later, count pulse-mode strobes.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (strobe === 1'b1) strobe_cnt++;
        end
    endtask

    initial begin
        // Reset held with key 4 pressed.
        in = 20'h00010;
        rst = 1'b0;
        tick(3);
        check("rst_out", out, 0);
        check("rst_strobe", strobe, 0);
        check("rst_multi", multi, 0);
        check("rst_lvl_strobe", lvl_strobe, 0);

        // Release reset: accept lands on E5.
        rst = 1'b1;
        strobe_cnt = 0;
        tick(5);
        check("rst_pre_accept_strobe", strobe, 0);
        tick(1);
        check("rst_accept_strobe", strobe, 1);
        check("rst_accept_out", out, 4);
        check("rst_accept_multi", multi, 0);
        check("rst_lvl_strobe_hi", lvl_strobe, 1);
        tick(1);
        check("rst_pulse_width", strobe, 0);
        check("rst_strobe_count", strobe_cnt, 1);

        // Level mode: strobe stays up until R5 after release.
        in = '0;
        tick(5);
        check("lvl_hold_R4", lvl_strobe, 1);
        tick(1);
        check("lvl_drop_R5", lvl_strobe, 0);
        check("lvl_out_held", lvl_out, 4);
        tick(4);

        // Key sweep.
        strobe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            base = strobe_cnt;
            in = 20'(1) << i;
            tick(8);
            check($sformatf("sweep_out_%0d", i), out, i);
            check($sformatf("sweep_multi_%0d", i), multi, 0);
            in = '0;
            tick(8);
            check($sformatf("sweep_strobes_%0d", i), strobe_cnt - base, 1);
        end
        check("sweep_total_strobes", strobe_cnt, 20);

        // Press bounce on key 7.
        base = strobe_cnt;
        for (int p = 0; p < 3; p++) begin
            in = 20'h00080;
            tick(2);
            in = '0;
            tick(2);
        end
        check("bounce_no_strobe", strobe_cnt - base, 0);
        in = 20'h00080;
        tick(5);
        check("bounce_pre_accept", strobe_cnt - base, 0);
        tick(1);
        check("bounce_accept_strobe", strobe, 1);
        check("bounce_out", out, 7);
        in = '0;
        tick(8);
        check("bounce_total", strobe_cnt - base, 1);

        // Multi-key: keys 3 and 12.
        base = strobe_cnt;
        in = 20'h01008;
        tick(6);
        check("multi_strobe", strobe, 1);
        check("multi_out", out, 12);
        check("multi_flag", multi, 1);
        tick(2);
        in = 20'h00008;
        tick(8);
        check("multi_drop_no_strobe", strobe_cnt - base, 1);
        check("multi_drop_out", out, 12);
        in = '0;
        tick(8);
        check("multi_after_release_out", out, 12);
        check("multi_after_release_flag", multi, 1);
        in = 20'h00008;
        tick(6);
        check("single3_strobe", strobe, 1);
        check("single3_out", out, 3);
        check("single3_multi", multi, 0);
        in = '0;
        tick(8);

        // Release bounce on key 9.
        base = strobe_cnt;
        in = 20'h00200;
        tick(8);
        check("relb_out", out, 9);
        in = '0;
        tick(2);
        in = 20'h00200;
        tick(1);
        in = '0;
        tick(5);
        check("relb_lvl_R4", lvl_strobe, 1);
        tick(1);
        check("relb_lvl_R5", lvl_strobe, 0);
        tick(4);
        check("relb_single_strobe", strobe_cnt - base, 1);
        check("relb_out_kept", out, 9);
        check("relb_lvl_out", lvl_out, 9);

        // Mid-operation reset with key 5 held.
        in = 20'h00020;
        tick(8);
        check("mid_pre_out", out, 5);
        rst = 1'b0;
        #1;
        check("mid_async_out", out, 0);
        check("mid_async_strobe", lvl_strobe, 0);
        check("mid_async_lvl_out", lvl_out, 0);
        tick(1);
        rst = 1'b1;
        base = strobe_cnt;
        tick(5);
        check("mid_pre_accept", strobe_cnt - base, 0);
        tick(1);
        check("mid_reaccept_strobe", strobe, 1);
        check("mid_reaccept_out", out, 5);
        check("mid_reaccept_multi", multi, 0);
        in = '0;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synckey_debounce.md
# synckey_debounce

Parametrised keypad front end: synchronises an N-bit raw key vector and debounces it on both press and release. It encodes the accepted key to a binary index and flags a new press with a strobe. It sits between the keypad pins and the door-lock code-entry FSM. It generalises the fixed 20-key synchroniser with configurable width, sync depth, debounce length, strobe mode, bounce rejection and multi-key detection.

## Interface
- NKEYS, 20, number of raw key inputs (≥2)
- SYNC_STAGES, 2, synchroniser flops per key (≥2)
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release (≥2)
- PULSE_MODE, 1, 1: strobe is a one-cycle pulse per accepted press; 0: strobe is a level from acceptance until release is accepted
- OUTW (localparam), $clog2(NKEYS), width of `out`; 5 for defaults
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- in  in  NKEYS  raw asynchronous key levels, 1 = pressed
- strobe  out  1  press event (pulse or level per PULSE_MODE)
- out  out  OUTW  index of the last accepted key
- multi  out  1  more than one key was set in the accepted vector

## Operation
- Each `in` bit passes through SYNC_STAGES flops, all reset to 0. `sv` = synchronised vector.
- Encoding: code = index of the highest set bit of the vector.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE. Counter `cnt` has width $clog2(DEBOUNCE_CYCLES+1).
- IDLE, sv≠0: capture cap=sv, set cnt=1, go to DEBOUNCE. If sv=0, stay.
- DEBOUNCE, sv==cap: if cnt==DEBOUNCE_CYCLES−1, accept and go to HELD; else cnt++.
- DEBOUNCE, sv≠cap and sv≠0: recapture cap=sv, set cnt=1, stay.
- DEBOUNCE, sv=0: go to IDLE. No outputs change.
- Accept: out ← code(cap); multi ← (popcount(cap)>1); strobe ← 1.
- HELD, sv≠0: stay. Changes in the nonzero pattern are ignored; no new strobe.
- HELD, sv=0: go to RELEASE, cnt=1.
- RELEASE, sv=0: if cnt==DEBOUNCE_CYCLES−1, go to IDLE; else cnt++.
- RELEASE, sv≠0: return to HELD. This is release bounce: no strobe, out unchanged.
- PULSE_MODE=1: strobe is high exactly one cycle, the cycle after the accept edge.
- PULSE_MODE=0: strobe is high from the accept edge until the edge entering IDLE from RELEASE.
- out and multi hold their value after release until the next accept.
- Reset (rst=0): immediately out=0, strobe=0, multi=0, cnt=0, cap=0, state=IDLE, all sync flops 0. Reset mid-operation discards any pending or held key. A key still held after rst rises is re-synchronised and re-debounced, and strobes again after the full latency.

## Timing
- E0 is the first rising edge sampling a new stable `in`.
- sv reflects it after edge E(SYNC_STAGES−1).
- IDLE captures at edge E(SYNC_STAGES).
- Accept occurs at edge E(SYNC_STAGES+DEBOUNCE_CYCLES−1); E5 for defaults.
- out, multi and strobe change together at the accept edge.
- Release: strobe drops (level mode) at edge R(SYNC_STAGES+DEBOUNCE_CYCLES−1) after the key falls; R5 for defaults.
- Minimum press-to-press spacing = 2×(SYNC_STAGES+DEBOUNCE_CYCLES−1) edges.
- All outputs are registered; no combinational path from `in`.

## Test plan
Defaults unless stated.
- Reset: hold rst=0 with in=20'h00010 -> out=0, strobe=0, multi=0. Release rst -> single strobe pulse after E5, out=4, multi=0.
- Key sweep: for i=0..19, press only bit i for 8 cycles, then release for 8 -> exactly one strobe per key, out=i, multi=0; 20 strobes total.
- Press bounce: toggle bit 7 every 2 cycles for 12 cycles, then hold -> no strobe while toggling. One strobe 5 edges after the last toggle; out=7.
- Multi-key: press in=bit3|bit12 -> out=12, multi=1, one strobe. Drop bit12 while bit3 held -> no strobe, out=12. Full release, then press bit3 -> out=3, multi=0.
- Release bounce / level mode:
  - Hold bit9, release, re-press for 1 cycle within 2 cycles -> no second strobe, out=9.
  - With PULSE_MODE=0 -> strobe high from E5 until R5 after the final release.
- Mid-operation reset: bit5 held in HELD, pull rst low for 1 cycle -> outputs 0 immediately, without waiting for a clock edge. With bit5 still held -> strobe again at E5 counted from the first edge after rst rises; out=5.
